pipe_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency data pipeline (32-bit data + valid in, same out, PIPE_LAT cycles later, no backpressure) among NUM_REQ requesters. It accepts one beat per cycle from a valid/ready requester port, launches it into the pipeline, and tracks the requester ID alongside the pipeline. When the result emerges, it routes the result back to the requester that issued the beat. It sits between the requester agents and the pipeline instance in the test top.

---
 rtl/pipe_rr_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: shares one fixed-latency, no-backpressure data pipeline among NUM_REQ
// requesters. A round-robin selector with burst hold picks one beat per cycle and launches
// it into the pipeline. A tag shadow carries the requester ID down a delay line, so each
// result returns to the requester that issued it. Mismatches between the pipeline valid and
// the shadow valid raise a sticky err_tag.
module pipe_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PIPE_LAT  = 3,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ-1:0]        en_mask,
  output logic [DATA_W-1:0]         pipe_data_in,
  output logic                      pipe_vld,
  input  logic [DATA_W-1:0]         pipe_data_out,
  input  logic                      pipe_data_vld,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      err_clr,
  output logic                      err_tag
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam int unsigned PosW = ID_W + 1;
  localparam logic [ID_W-1:0] LastId   = ID_W'(NUM_REQ - 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_LEN);

  // Arbitration state
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  // Selection
  logic [NUM_REQ-1:0] elig;
  logic               scan_hit;
  logic [ID_W-1:0]    scan_sel;
  logic               hold;
  logic [ID_W-1:0]    sel;
  logic               xfer;
  logic [DATA_W-1:0]  sel_data;

  // Launch register
  logic              pipe_vld_q;
  logic [DATA_W-1:0] pipe_data_q;
  logic [ID_W-1:0]   launch_id_q;

  // Tag shadow, stage PIPE_LAT-1 lines up with pipe_data_vld
  logic [PIPE_LAT-1:0]           sh_vld_q;
  logic [PIPE_LAT-1:0][ID_W-1:0] sh_id_q;
  logic                          tag_vld;
  logic [ID_W-1:0]               tag_id;

  // Response / error
  logic [NUM_REQ-1:0] rsp_vld_d;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               err_q;

  assign elig = req_vld & en_mask;

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PosW-1:0] pos;
    scan_hit = 1'b0;
    scan_sel = '0;
    pos      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr_q} + PosW'(i);
      if (pos >= PosW'(NUM_REQ)) begin
        pos = pos - PosW'(NUM_REQ);
      end
      if (!scan_hit && elig[pos[ID_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_sel = pos[ID_W-1:0];
      end
    end
  end

  // Burst hold keeps the last winner while it stays eligible and has burst budget left.
  assign hold = (burst_cnt_q < BurstMax) && elig[last_q];
  assign sel  = hold ? last_q : scan_sel;
  // No grants while reset is asserted, so req_rdy reads 0 during reset.
  assign xfer = !reset && (hold || scan_hit);

  // Decode the grant to req_rdy and mux the selected requester's beat.
  always_comb begin
    req_rdy  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        req_rdy[i] = xfer;
        sel_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next arbitration state: rotate past the winner, count bursts, idle clears the burst.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      rr_ptr_d = (sel == LastId) ? '0 : sel + 1'b1;
      last_d   = sel;
      if (sel != last_q) begin
        burst_cnt_d = CntW'(1);
      end else if (burst_cnt_q != BurstMax) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      last_q      <= '0;
      burst_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Launch register: data and ID hold when no beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
      launch_id_q <= '0;
    end else begin
      pipe_vld_q <= xfer;
      if (xfer) begin
        pipe_data_q <= sel_data;
        launch_id_q <= sel;
      end
    end
  end

  assign pipe_vld     = pipe_vld_q;
  assign pipe_data_in = pipe_data_q;

  // Tag shadow shifts every cycle, mirroring the pipeline's fixed latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_vld_q <= '0;
      sh_id_q  <= '0;
    end else begin
      sh_vld_q[0] <= pipe_vld_q;
      sh_id_q[0]  <= launch_id_q;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        sh_vld_q[k] <= sh_vld_q[k-1];
        sh_id_q[k]  <= sh_id_q[k-1];
      end
    end
  end

  assign tag_vld = sh_vld_q[PIPE_LAT-1];
  assign tag_id  = sh_id_q[PIPE_LAT-1];

  // One-hot response valid for the tag owner, qualified by the pipeline valid.
  always_comb begin
    rsp_vld_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_vld_d[i] = pipe_data_vld && (tag_id == ID_W'(i));
    end
  end

  // Response register and sticky error; a new mismatch beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (tag_vld) begin
        rsp_vld_q  <= rsp_vld_d;
        rsp_data_q <= pipe_data_out;
        rsp_id_q   <= tag_id;
      end else begin
        rsp_vld_q <= '0;
      end
      if (pipe_data_vld != tag_vld) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;
  assign err_tag  = err_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter: identity pipeline model, grant table, hand-written corner
// sequences and a randomized phase checked against a scoreboard-based reference model.
module tb_pipe_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PL = 3;
  localparam int BL = 2;
  localparam int RL = PL + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_rdy;
  logic [N-1:0]  en_mask;
  logic [DW-1:0] pipe_data_in;
  logic          pipe_vld;
  logic [DW-1:0] pipe_data_out;
  logic          pipe_data_vld;
  logic [N-1:0]  rsp_vld;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          err_clr;
  logic          err_tag;
  logic          force_pv;

  always #5 clk = ~clk;

  pipe_rr_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .PIPE_LAT (PL),
    .BURST_LEN(BL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .en_mask      (en_mask),
    .pipe_data_in (pipe_data_in),
    .pipe_vld     (pipe_vld),
    .pipe_data_out(pipe_data_out),
    .pipe_data_vld(pipe_data_vld),
    .rsp_vld      (rsp_vld),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .err_clr      (err_clr),
    .err_tag      (err_tag)
  );

  // Identity pipeline of fixed latency PL, reset together with the DUT.
  logic [PL-1:0]         pl_vld;
  logic [PL-1:0][DW-1:0] pl_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pl_vld  <= '0;
      pl_data <= '0;
    end else begin
      pl_vld[0]  <= pipe_vld;
      pl_data[0] <= pipe_data_in;
      for (int k = 1; k < PL; k++) begin
        pl_vld[k]  <= pl_vld[k-1];
        pl_data[k] <= pl_data[k-1];
      end
    end
  end
  assign pipe_data_vld = pl_vld[PL-1] | force_pv;
  assign pipe_data_out = pl_data[PL-1];

  // Reference model state
  typedef struct { int rc; int id; logic [DW-1:0] d; } rsp_t;
  rsp_t          sbq[$];
  int            m_ptr, m_last, m_cnt;
  logic          m_err, exp_pv;
  logic [DW-1:0] m_pd, m_rd;
  logic [1:0]    m_rid;
  logic [N-1:0]  exp_rv;
  logic [N-1:0]  seen_rdy;
  int            cyc;
  int            checks;
  int            errors;

  typedef struct { logic [N-1:0] v; logic [N-1:0] m; int g; } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] el);
    if (m_cnt < BL && el[m_last]) return m_last;
    for (int k = 0; k < N; k++) begin
      if (el[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_last = 0; m_cnt = 0;
    m_err = 1'b0; exp_pv = 1'b0; m_pd = '0; m_rd = '0; m_rid = '0; exp_rv = '0;
    sbq.delete();
  endtask

  // One clock cycle: drive at negedge, check req_rdy, then check registered outputs.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] m, input logic [N*DW-1:0] d,
                      input logic clr, input logic frc);
    int   g;
    logic tag_now;
    rsp_t e;
    req_vld = v; en_mask = m; req_data = d; err_clr = clr; force_pv = frc;
    #1;
    g = pick(v & m);
    seen_rdy = req_rdy;
    chk("req_rdy", req_rdy, (g < 0) ? 4'b0 : 4'(1 << g));
    tag_now = (sbq.size() > 0) && (sbq[0].rc == cyc + 1);
    exp_pv = (g >= 0);
    if (g >= 0) begin
      e.rc = cyc + RL; e.id = g; e.d = d[g*DW +: DW];
      sbq.push_back(e);
      m_pd = e.d;
    end
    if (tag_now) begin
      e = sbq.pop_front();
      exp_rv = 4'(1 << e.id); m_rd = e.d; m_rid = 2'(e.id);
    end else begin
      exp_rv = '0;
    end
    if (frc && !tag_now) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (g < 0) begin
      m_cnt = 0;
    end else begin
      m_cnt  = (g == m_last) ? ((m_cnt + 1 > BL) ? BL : m_cnt + 1) : 1;
      m_last = g;
      m_ptr  = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("pipe_vld", pipe_vld, exp_pv);
    chk("pipe_data_in", pipe_data_in, m_pd);
    chk("rsp_vld", rsp_vld, exp_rv);
    chk("rsp_data", rsp_data, m_rd);
    chk("rsp_id", rsp_id, m_rid);
    chk("err_tag", err_tag, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 4'hF, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    req_vld = 4'hF; en_mask = 4'hF; force_pv = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_req_rdy", req_rdy, 4'b0);
    chk("rst_pipe_vld", pipe_vld, 1'b0);
    chk("rst_pipe_data_in", pipe_data_in, 32'h0);
    chk("rst_rsp_vld", rsp_vld, 4'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_id", rsp_id, 2'b0);
    chk("rst_err_tag", err_tag, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic add(input logic [N-1:0] v, input logic [N-1:0] m, input int g);
    vec_t r;
    r.v = v; r.m = m; r.g = g;
    tbl.push_back(r);
  endtask

  logic [N*DW-1:0] vd;
  int t0, nxt, first_c, last_c;
  logic saw;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    model_reset();
    reset = 1'b1; req_vld = '0; en_mask = '0; req_data = '0; err_clr = 1'b0; force_pv = 1'b0;

    // Grant table: contention, wrap-around, mask, mid-burst unmask.
    for (int i = 0; i < 8; i++) add(4'hF, 4'hF, i / 2);
    add(4'b0100, 4'hF, 2);
    add(4'b1001, 4'hF, 3); add(4'b1001, 4'hF, 3);
    add(4'b1001, 4'hF, 0); add(4'b1001, 4'hF, 0);
    add(4'b1001, 4'hF, 3); add(4'b1001, 4'hF, 3);
    add(4'hF, 4'b1011, 0); add(4'hF, 4'b1011, 0);
    add(4'hF, 4'b1011, 1); add(4'hF, 4'b1011, 1);
    add(4'hF, 4'b1011, 3); add(4'hF, 4'b1011, 3);
    add(4'hF, 4'b1011, 0);
    add(4'hF, 4'b1010, 1);
    add(4'b0000, 4'hF, -1);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("init_pipe_vld", pipe_vld, 1'b0);
    chk("init_pipe_data_in", pipe_data_in, 32'h0);
    chk("init_rsp_vld", rsp_vld, 4'b0);
    chk("init_rsp_data", rsp_data, 32'h0);
    chk("init_rsp_id", rsp_id, 2'b0);
    chk("init_err_tag", err_tag, 1'b0);

    // Single beat from requester 2.
    t0 = cyc;
    step(4'b0100, 4'hF, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1'b0, 1'b0);
    chk("single_rdy", seen_rdy, 4'b0100);
    chk("single_pipe_vld", pipe_vld, 1'b1);
    idle(4);
    chk("single_latency", cyc - t0, 5);
    chk("single_rsp_vld", rsp_vld, 4'b0100);
    chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("single_rsp_id", rsp_id, 2'd2);
    idle(2);

    // Table-driven grant sequence from a fresh reset.
    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      for (int w = 0; w < N; w++) vd[w*DW +: DW] = 32'hA000_0000 + 32'(r * 16 + w);
      step(tbl[r].v, tbl[r].m, vd, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_grant", r), seen_rdy, (tbl[r].g < 0) ? 4'b0 : 4'(1 << tbl[r].g));
    end
    idle(6);

    // Back-to-back stream of 20 beats from requester 1.
    nxt = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 26; i++) begin
      vd = '0;
      if (i < 20) vd[DW +: DW] = 32'(i);
      step((i < 20) ? 4'b0010 : 4'b0000, 4'hF, vd, 1'b0, 1'b0);
      if (rsp_vld == 4'b0010) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (rsp_data == 32'(nxt)) nxt++;
      end
    end
    chk("stream_in_order", nxt, 20);
    chk("stream_contiguous", last_c - first_c + 1, 20);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      for (int w = 0; w < N; w++) vd[w*DW +: DW] = $urandom;
      step(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, vd,
           ($urandom_range(0, 15) == 0), 1'b0);
    end
    idle(6);

    // Spurious pipeline valid with no launch sets a sticky error.
    step('0, 4'hF, '0, 1'b0, 1'b1);
    chk("err_set", err_tag, 1'b1);
    chk("err_no_rsp", rsp_vld, 4'b0);
    idle(3);
    chk("err_sticky", err_tag, 1'b1);
    step('0, 4'hF, '0, 1'b1, 1'b1);
    chk("err_set_beats_clr", err_tag, 1'b1);
    step('0, 4'hF, '0, 1'b1, 1'b0);
    chk("err_cleared", err_tag, 1'b0);
    idle(2);

    // Reset with three beats in flight: nothing must come back.
    for (int i = 0; i < 3; i++) step(4'b0001, 4'hF, 128'(32'h5A00 + i), 1'b0, 1'b0);
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step('0, 4'hF, '0, 1'b0, 1'b0);
      if (rsp_vld != 4'b0) saw = 1'b1;
    end
    chk("no_rsp_after_reset", saw, 1'b0);
    chk("no_err_after_reset", err_tag, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
